// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, major opcodes and the immediate format tags.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_S_TYPE = 7'b0100011;
    localparam logic [6:0] OPCODE_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_J_TYPE = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_I_ALU  = 3'd0,
        FMT_I_LD   = 3'd1,
        FMT_I_JALR = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4,
        FMT_LUI    = 3'd5,
        FMT_AUIPC  = 3'd6,
        FMT_J      = 3'd7
    } imm_fmt_t;

    // Major opcode emitted for each immediate format.
    function automatic logic [6:0] fmt_opcode(input imm_fmt_t fmt);
        logic [6:0] opc;
        case (fmt)
            FMT_I_ALU:  opc = OPCODE_OP_IMM;
            FMT_I_LD:   opc = OPCODE_LOAD;
            FMT_I_JALR: opc = OPCODE_JALR;
            FMT_S:      opc = OPCODE_S_TYPE;
            FMT_B:      opc = OPCODE_B_TYPE;
            FMT_LUI:    opc = OPCODE_LUI;
            FMT_AUIPC:  opc = OPCODE_AUIPC;
            FMT_J:      opc = OPCODE_J_TYPE;
            default:    opc = 7'd0;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: scatters a full-width immediate into the
// instruction word for the given format and flags unrepresentable values.
module imm_pack
    import rv32i_pkg::*;
(
    input  imm_fmt_t         fmt,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  imm,
    output logic [ILEN-1:0]  instr,
    output logic             err
);

    // A value fits a signed N-bit field when every bit from N-1 upward agrees.
    logic fits_12;
    logic fits_13;
    logic fits_21;
    logic [6:0] opc;

    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);
    assign opc     = fmt_opcode(fmt);

    // Format-dependent packing; the truncated encoding is produced even on err.
    always_comb begin
        instr = '0;
        err   = 1'b0;
        case (fmt)
            FMT_I_ALU, FMT_I_LD, FMT_I_JALR: begin
                instr = {imm[11:0], rs1, funct3, rd, opc};
                err   = ~fits_12;
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc};
                err   = ~fits_12;
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc};
                err   = ~fits_13 | imm[0];
            end
            FMT_LUI, FMT_AUIPC: begin
                instr = {imm[31:12], rd, opc};
                err   = |imm[11:0];
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                err   = ~fits_21 | imm[0];
            end
            default: begin
                instr = '0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder with saturating ok/error counters.
module instr_encoder
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ILEN-1:0]   out_instr,
    output logic              out_err,
    output logic [CNT_W-1:0]  cnt_ok,
    output logic [CNT_W-1:0]  cnt_err
);

    logic             s1_valid_reg;
    imm_fmt_t         s1_fmt_reg;
    logic [4:0]       s1_rd_reg;
    logic [4:0]       s1_rs1_reg;
    logic [4:0]       s1_rs2_reg;
    logic [2:0]       s1_funct3_reg;
    logic [XLEN-1:0]  s1_imm_reg;

    logic             s2_valid_reg;
    logic [ILEN-1:0]  s2_instr_reg;
    logic             s2_err_reg;

    logic [ILEN-1:0]  pack_instr;
    logic             pack_err;
    logic             s2_load;
    logic             in_fire;
    logic             out_fire;

    // S2 can take a new word when empty or when its current word leaves now.
    assign out_fire = s2_valid_reg & out_ready;
    assign s2_load  = ~s2_valid_reg | out_fire;
    assign in_ready = ~s1_valid_reg | s2_load;
    assign in_fire  = in_valid & in_ready;

    imm_pack u_pack (
        .fmt    (s1_fmt_reg),
        .rd     (s1_rd_reg),
        .rs1    (s1_rs1_reg),
        .rs2    (s1_rs2_reg),
        .funct3 (s1_funct3_reg),
        .imm    (s1_imm_reg),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // Stage 1: capture the request; empties when its entry moves into S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_fmt_reg    <= FMT_I_ALU;
            s1_rd_reg     <= '0;
            s1_rs1_reg    <= '0;
            s1_rs2_reg    <= '0;
            s1_funct3_reg <= '0;
            s1_imm_reg    <= '0;
        end else if (in_fire) begin
            s1_valid_reg  <= 1'b1;
            s1_fmt_reg    <= imm_fmt_t'(in_fmt);
            s1_rd_reg     <= in_rd;
            s1_rs1_reg    <= in_rs1;
            s1_rs2_reg    <= in_rs2;
            s1_funct3_reg <= in_funct3;
            s1_imm_reg    <= in_imm;
        end else if (s2_load) begin
            s1_valid_reg  <= 1'b0;
        end
    end

    // Stage 2: hold the encoded word steady until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= '0;
            s2_err_reg   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_instr_reg <= pack_instr;
                s2_err_reg   <= pack_err;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_instr = s2_instr_reg;
    assign out_err   = s2_err_reg;

    // Index 0 counts clean words, index 1 flagged words; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             hit;

            assign hit = out_fire & (s2_err_reg == 1'(gi));

            // Saturating increment on each matching output handshake.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (hit && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign cnt_ok  = g_cnt[0].cnt_reg;
    assign cnt_err = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, scoreboard, corner sequences.
module tb_instr_encoder;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [CW-1:0] cnt_ok;
    logic [CW-1:0] cnt_err;

    instr_encoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_ok    (cnt_ok),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rt;    // 1: round-trip check of decoded immediate
        logic [2:0]  fmt;
        logic [31:0] val;   // expected instr, or expected immediate when rt
        logic        err;
    } sb_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    sb_t sb[$];
    int  fire_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference immediate extraction, as the decoder's imm_gen sees it.
    function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] i);
        case (f)
            3'd0, 3'd1, 3'd2: return {{20{i[31]}}, i[31:20]};
            3'd3:             return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd4:             return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd5, 3'd6:       return {i[31:12], 12'h000};
            default:          return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: every handshake pops and checks one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            fire_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_output", out_instr, 32'hxxxx_xxxx);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.rt) begin
                    chk("roundtrip_imm", decode_imm(e.fmt, out_instr), e.val);
                    chk("roundtrip_err", {31'd0, out_err}, 32'd0);
                end else begin
                    chk("out_instr", out_instr, e.val);
                    chk("out_err", {31'd0, out_err}, {31'd0, e.err});
                end
                $display("out: instr=%h err=%0d cnt_ok=%0d cnt_err=%0d", out_instr, out_err, cnt_ok, cnt_err);
            end
        end
    end

    // Offer one request (called just after a rising edge) until accepted.
    task automatic send(input logic [2:0] f, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                        input logic [4:0] rs2_i, input logic [2:0] f3, input logic [31:0] imm,
                        input sb_t e);
        int   n;
        logic acc;
        in_fmt = f; in_rd = rd_i; in_rs1 = rs1_i; in_rs2 = rs2_i;
        in_funct3 = f3; in_imm = imm; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        if (acc) begin
            sb.push_back(e);
            $display("in: fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h", f, rd_i, rs1_i, rs2_i, f3, imm);
        end else begin
            chk("accept_timeout", {31'd0, acc}, 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic sb_t mk(input logic [31:0] v, input logic e);
        sb_t s;
        s.rt = 1'b0; s.fmt = 3'd0; s.val = v; s.err = e;
        return s;
    endfunction

    vec_t vecs[7];

    initial begin
        sb_t         ea;
        sb_t         eb;
        sb_t         ec;
        sb_t         er;
        logic [31:0] r;
        logic [31:0] imm;
        logic [2:0]  f;

        vecs[0] = '{3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        vecs[1] = '{3'd4, 5'd0, 5'd1, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_8EE3, 1'b0};
        vecs[2] = '{3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[3] = '{3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0};
        vecs[4] = '{3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0003, 32'h0000_0163, 1'b1};
        vecs[5] = '{3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'h8000_0013, 1'b1};
        vecs[6] = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h1234_5037, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_cnt_ok", {28'd0, cnt_ok}, 32'd0);
        chk("rst_cnt_err", {28'd0, cnt_err}, 32'd0);
        @(posedge clk);
        #1;

        // Vector table: encodings and error flags
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].fmt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].imm,
                 mk(vecs[i].exp_instr, vecs[i].exp_err));
        end
        drain();
        chk("tbl_cnt_ok", {28'd0, cnt_ok}, 32'd4);
        chk("tbl_cnt_err", {28'd0, cnt_err}, 32'd3);

        // Backpressure: two accepted, third blocked, stable output, ordered drain
        out_ready = 1'b0;
        ea = mk(32'h0010_0093, 1'b0);   // addi x1, x0, 1
        eb = mk(32'h0020_0113, 1'b0);   // addi x2, x0, 2
        ec = mk(32'h0030_0193, 1'b0);   // addi x3, x0, 3
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, ea);
        send(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2, eb);
        in_fmt = 3'd0; in_rd = 5'd3; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0;
        in_imm = 32'd3; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_stable", out_instr, 32'h0010_0093);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        fire_q.delete();
        send(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3, ec);
        drain();
        chk("bp_fire_count", fire_q.size(), 3);
        if (fire_q.size() == 3) chk("bp_consecutive", fire_q[2] - fire_q[0], 2);

        // Full throughput after a clean reset
        do_reset();
        fire_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(3'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'(i),
                 mk({12'(i), 5'd0, 3'd0, 5'(i + 1), 7'b0010011}, 1'b0));
        end
        drain();
        chk("tp_fire_count", fire_q.size(), 8);
        if (fire_q.size() == 8) chk("tp_no_bubbles", fire_q[7] - fire_q[0], 7);
        chk("tp_cnt_ok", {28'd0, cnt_ok}, 32'd8);

        // Counter saturation at all-ones
        for (int i = 0; i < 10; i++) begin
            send(3'd5, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0000_1000,
                 mk({20'h00001, 5'd7, 7'b0110111}, 1'b0));
        end
        drain();
        chk("sat_cnt_ok", {28'd0, cnt_ok}, 32'd15);
        chk("sat_cnt_err", {28'd0, cnt_err}, 32'd0);

        // Round trip of random legal immediates through the reference decoder
        for (int i = 0; i < 32; i++) begin
            f = 3'(i % 8);
            r = $urandom;
            case (f)
                3'd0, 3'd1, 3'd2, 3'd3: imm = {{20{r[11]}}, r[11:0]};
                3'd4:                   imm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd5, 3'd6:             imm = {r[31:12], 12'h000};
                default:                imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            er.rt = 1'b1; er.fmt = f; er.val = imm; er.err = 1'b0;
            send(f, 5'(r[4:0]), 5'(r[9:5]), 5'(r[14:10]), 3'(r[17:15]), imm, er);
        end
        drain();

        // Reset with both stages full: nothing in flight may emerge
        out_ready = 1'b0;
        send(3'd0, 5'd9, 5'd0, 5'd0, 3'd0, 32'd9, mk(32'h0090_0493, 1'b0));
        send(3'd0, 5'd10, 5'd0, 5'd0, 3'd0, 32'd10, mk(32'h00A0_0513, 1'b0));
        @(negedge clk);
        chk("mr_full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_cnt_ok", {28'd0, cnt_ok}, 32'd0);
        chk("mr_cnt_err", {28'd0, cnt_err}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mr_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
